pingpong_stream_buf: RTL and testbench



---
 rtl/pingpong_pkg.sv | 22 ++
 rtl/pingpong_bank_mem.sv | 37 +++
 rtl/pingpong_stream_buf.sv | 130 +++++++++++++
 tb/tb_pingpong_stream_buf.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_pkg
// Shared types and constants for the ping-pong stream buffer.
//   bank_idx_t     : selects one of the two banks
//   DEF_DATA_W     : default data word width
//   DEF_DEPTH      : default number of words per bank
//   addr_w()       : address width needed to index a bank of a given depth
// ---------------------------------------------------------------------------
package pingpong_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   typedef logic bank_idx_t;

   // A bank of depth 1 still needs one address bit so ports never collapse
   // to zero width.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pingpong_bank_mem.sv
// ---------------------------------------------------------------------------
// pingpong_bank_mem
// One DEPTH x DATA_W register-array bank with a synchronous write port and
// an asynchronous (combinational) read port.
//   clk      : clock, writes happen on the rising edge
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data, combinational from rd_addr
// ---------------------------------------------------------------------------
module pingpong_bank_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; contents only become visible once
   // the owning frame has been closed by the writer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pingpong_stream_buf.sv
// ---------------------------------------------------------------------------
// pingpong_stream_buf
// Double-bank (ping-pong) frame buffer with valid/ready on both sides. The
// writer fills one bank while the reader drains the other; each side swaps
// banks independently when a frame closes (bank filled or in_last).
//   clk            : clock, all logic on the rising edge
//   rst            : synchronous reset, active-high
//   in_valid/in_ready/in_data/in_last     : write stream
//   out_valid/out_ready/out_data/out_last : read stream
//   bank_full      : per-bank "closed frame present" flags
//   frames_pending : number of closed, unread frames (0..2)
// ---------------------------------------------------------------------------
module pingpong_stream_buf
   import pingpong_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        bank_full,
   output logic [1:0]        frames_pending
);

   bank_idx_t                wr_bank_q, wr_bank_d;
   bank_idx_t                rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
   logic [1:0]               bank_full_q, bank_full_d;
   logic [1:0][ADDR_W:0]     bank_len_q, bank_len_d;

   logic                     wr_accept;
   logic                     rd_accept;
   logic [DATA_W-1:0]        bank_rd_data [2];

   // Handshake outputs: the writer may only touch an empty bank and the
   // reader only presents a closed one, so set and clear of a single bank
   // can never collide.
   assign in_ready       = !rst && !bank_full_q[wr_bank_q];
   assign out_valid      = bank_full_q[rd_bank_q];
   assign out_data       = bank_rd_data[rd_bank_q];
   assign out_last       = out_valid &&
                           ({1'b0, rd_addr_q} == (bank_len_q[rd_bank_q] - (ADDR_W+1)'(1)));
   assign bank_full      = bank_full_q;
   assign frames_pending = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};

   assign wr_accept = in_valid && in_ready;
   assign rd_accept = out_valid && out_ready;

   // Two identical banks; only the bank the writer currently owns sees the
   // write enable, and the read address is shared because only the reader's
   // bank is ever selected onto out_data.
   for (genvar g = 0; g < 2; g++) begin : g_bank
      pingpong_bank_mem #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_accept && (wr_bank_q == bank_idx_t'(g))),
         .wr_addr (wr_addr_q),
         .wr_data (in_data),
         .rd_addr (rd_addr_q),
         .rd_data (bank_rd_data[g])
      );
   end

   // Next-state for both pointers. A write close and a read release in the
   // same cycle always target different banks, so both updates to
   // bank_full_d are applied together.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      bank_full_d = bank_full_q;
      bank_len_d  = bank_len_q;

      if (wr_accept) begin
         if ((wr_addr_q == ADDR_W'(DEPTH - 1)) || in_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            bank_len_d[wr_bank_q]  = {1'b0, wr_addr_q} + (ADDR_W+1)'(1);
            wr_bank_d              = ~wr_bank_q;
            wr_addr_d              = '0;
         end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
         end
      end

      if (rd_accept) begin
         if (out_last) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_addr_d              = '0;
         end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
         end
      end
   end

   // State registers. Reset discards any partial or closed frames; the
   // stored lengths are cleared too so a stale length can never be used.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         bank_full_q <= '0;
         bank_len_q  <= '0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         bank_full_q <= bank_full_d;
         bank_len_q  <= bank_len_d;
      end
   end

endmodule

// File: tb/tb_pingpong_stream_buf.sv
// ---------------------------------------------------------------------------
// tb_pingpong_stream_buf
// Self-checking bench for pingpong_stream_buf with DATA_W=8, DEPTH=4. A
// frame-level model (queues of closed frames) predicts every output each
// cycle; directed sequences add literal expectations, then a randomized
// phase streams 1000 words.
// ---------------------------------------------------------------------------
module tb_pingpong_stream_buf;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [1:0]        bank_full;
   logic [1:0]        frames_pending;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   pingpong_stream_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .bank_full      (bank_full),
      .frames_pending (frames_pending)
   );

   // Frame-level model: words of the frame being written, a flat queue of
   // words belonging to closed frames, and the lengths of those frames.
   // Closed frame number k (counted since reset) lives in bank k%2.
   logic [DATA_W-1:0] part_q [$];
   logic [DATA_W-1:0] word_q [$];
   int                len_q  [$];
   int                rd_idx = 0;
   int                wr_frames = 0;
   int                rd_frames = 0;
   int                words_accepted = 0;

   // Advance the model on every rising edge using the pre-edge inputs and
   // the model's own view of what the buffer can accept and present.
   always @(posedge clk) begin
      bit acc_w;
      bit acc_r;
      if (rst) begin
         part_q.delete();
         word_q.delete();
         len_q.delete();
         rd_idx    = 0;
         wr_frames = 0;
         rd_frames = 0;
      end else begin
         acc_w = in_valid && (len_q.size() < 2);
         acc_r = out_ready && (len_q.size() > 0);
         if (acc_r) begin
            void'(word_q.pop_front());
            rd_idx++;
            if (rd_idx == len_q[0]) begin
               void'(len_q.pop_front());
               rd_idx = 0;
               rd_frames++;
            end
         end
         if (acc_w) begin
            words_accepted++;
            part_q.push_back(in_data);
            if ((part_q.size() == DEPTH) || in_last) begin
               len_q.push_back(part_q.size());
               foreach (part_q[i]) word_q.push_back(part_q[i]);
               part_q.delete();
               wr_frames++;
            end
         end
      end
   end

   function automatic logic [1:0] expBankFull();
      logic [1:0] b = 2'b00;
      for (int k = rd_frames; k < wr_frames; k++) b[k % 2] = 1'b1;
      return b;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model away from the active edge.
   task automatic checkOutput();
      checkVal("in_ready", 32'(in_ready), 32'(!rst && (len_q.size() < 2)));
      checkVal("out_valid", 32'(out_valid), 32'(len_q.size() > 0));
      checkVal("frames_pending", 32'(frames_pending), 32'(len_q.size()));
      checkVal("bank_full", 32'(bank_full), 32'(expBankFull()));
      if (len_q.size() > 0) begin
         checkVal("out_data", 32'(out_data), 32'(word_q[0]));
         checkVal("out_last", 32'(out_last), 32'(rd_idx == len_q[0] - 1));
      end
   endtask

   always @(negedge clk) begin
      if (check_en) checkOutput();
   end

   // Drive one cycle of inputs, then return just after the next rising edge.
   task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit l,
                                input bit r, input bit rs);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      rst       = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);
   endtask

   logic [DATA_W-1:0] t3_words [6];
   int                target;
   int                budget;

   initial begin
      // Reset state
      doReset();
      check_en = 1'b1;
      checkVal("rst_in_ready", 32'(in_ready), 32'd0);
      checkVal("rst_out_valid", 32'(out_valid), 32'd0);
      checkVal("rst_pending", 32'(frames_pending), 32'd0);
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkVal("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Full frame 0x10..0x13 with reader ready
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'h10 + 8'(i), 0, 1, 0);
      checkVal("t1_out_valid", 32'(out_valid), 32'd1);
      checkVal("t1_out_data", 32'(out_data), 32'h10);
      checkVal("t1_pending", 32'(frames_pending), 32'd1);
      checkVal("t1_bank_full", 32'(bank_full), 32'b01);
      for (int i = 0; i < 4; i++) begin
         checkVal("t1_rd_data", 32'(out_data), 32'h10 + 32'(i));
         checkVal("t1_rd_last", 32'(out_last), 32'(i == 3));
         applyStimulus(0, 8'h00, 0, 1, 0);
      end
      checkVal("t1_pending_end", 32'(frames_pending), 32'd0);

      // Both banks fill, writer stalls on 0x28 until the reader frees bank0
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1, 8'h20 + 8'(i), 0, 0, 0);
      checkVal("t2_in_ready", 32'(in_ready), 32'd0);
      checkVal("t2_pending", 32'(frames_pending), 32'd2);
      checkVal("t2_bank_full", 32'(bank_full), 32'b11);
      applyStimulus(1, 8'h28, 0, 0, 0);
      applyStimulus(1, 8'h28, 0, 0, 0);
      checkVal("t2_stall", 32'(in_ready), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'h28, 0, 1, 0);
      checkVal("t2_release", 32'(in_ready), 32'd1);
      checkVal("t2_next_frame", 32'(out_data), 32'h24);
      applyStimulus(1, 8'h28, 0, 1, 0);
      applyStimulus(1, 8'h29, 1, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 1, 0);
      checkVal("t2_drained", 32'(frames_pending), 32'd0);

      // Short frame A0,A1 followed by a full frame B0..B3
      t3_words = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
      applyStimulus(1, 8'hA0, 0, 0, 0);
      applyStimulus(1, 8'hA1, 1, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'hB0 + 8'(i), 0, 0, 0);
      checkVal("t3_bank_full", 32'(bank_full), 32'b11);
      for (int i = 0; i < 6; i++) begin
         checkVal("t3_rd_data", 32'(out_data), 32'(t3_words[i]));
         checkVal("t3_rd_last", 32'(out_last), 32'((i == 1) || (i == 5)));
         applyStimulus(0, 8'h00, 0, 1, 0);
      end

      // Single-word frame
      applyStimulus(1, 8'hC5, 1, 0, 0);
      checkVal("t4_data", 32'(out_data), 32'hC5);
      checkVal("t4_last", 32'(out_last), 32'd1);
      checkVal("t4_pending", 32'(frames_pending), 32'd1);
      applyStimulus(0, 8'h00, 0, 1, 0);
      checkVal("t4_pending_end", 32'(frames_pending), 32'd0);

      // Reader releases bank0 on the same edge the writer closes bank1
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'hD0 + 8'(i), 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'hE0 + 8'(i), 0, 1, 0);
      checkVal("t5_before", 32'(bank_full), 32'b01);
      applyStimulus(1, 8'hE3, 0, 1, 0);
      checkVal("t5_after", 32'(bank_full), 32'b10);
      checkVal("t5_data", 32'(out_data), 32'hE0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 1, 0);

      // Reset with one bank full and the other half written
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'h40 + 8'(i), 0, 0, 0);
      applyStimulus(1, 8'hF0, 0, 0, 0);
      applyStimulus(1, 8'hF1, 0, 0, 0);
      checkVal("t6_pre_pending", 32'(frames_pending), 32'd1);
      applyStimulus(0, 8'h00, 0, 0, 1);
      checkVal("t6_out_valid", 32'(out_valid), 32'd0);
      checkVal("t6_pending", 32'(frames_pending), 32'd0);
      checkVal("t6_in_ready_rst", 32'(in_ready), 32'd0);
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkVal("t6_in_ready", 32'(in_ready), 32'd1);

      // Random traffic: 1000 accepted words, each compared by the model
      target = words_accepted + 1000;
      budget = 0;
      while ((words_accepted < target) && (budget < 20000)) begin
         applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) < 6, 0);
         budget++;
      end
      checks++;
      if (words_accepted < target) begin
         errors++;
         $display("[TB] FAIL random_budget: accepted %0d words, required %0d", words_accepted, target);
      end
      applyStimulus(1, 8'h5A, 1, 1, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 8'h00, 0, 1, 0);
      checkVal("final_pending", 32'(frames_pending), 32'd0);

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
